// File: rtl/atm_bank_core_if.sv
// Request/response bundle for the ATM transaction core.
// master = requester side, slave = core side.
interface atm_bank_core_if #(
    parameter int unsigned ACC_W = 4,
    parameter int unsigned PIN_W = 16,
    parameter int unsigned BAL_W = 32
);
    logic             req_valid;
    logic             req_ready;
    logic [2:0]       operation;
    logic [ACC_W-1:0] acc_num;
    logic [PIN_W-1:0] pin;
    logic [PIN_W-1:0] new_pin;
    logic [BAL_W-1:0] amount;
    logic             day_rollover;
    logic             rsp_valid;
    logic             success;
    logic [2:0]       error_code;
    logic [BAL_W-1:0] balance;
    logic [2:0]       state;

    modport master (
        output req_valid, operation, acc_num, pin, new_pin, amount, day_rollover,
        input  req_ready, rsp_valid, success, error_code, balance, state
    );

    modport slave (
        input  req_valid, operation, acc_num, pin, new_pin, amount, day_rollover,
        output req_ready, rsp_valid, success, error_code, balance, state
    );
endinterface

// File: rtl/atm_bank_core.sv
// ATM transaction engine with on-chip account database: authentication, lockout,
// daily withdrawal limit, deposit overflow protection and error codes.
module atm_bank_core #(
    parameter int unsigned NUM_ACCOUNTS = 10,
    parameter int unsigned ACC_W        = 4,
    parameter int unsigned PIN_W        = 16,
    parameter int unsigned BAL_W        = 32,
    parameter int unsigned DEFAULT_PIN  = 1234,
    parameter int unsigned INIT_BAL     = 5000,
    parameter int unsigned MAX_TRIES    = 3,
    parameter int unsigned WD_LIMIT     = 20000
) (
    input logic clk,
    input logic rst,
    atm_bank_core_if.slave bus
);
    localparam int unsigned FAIL_W = $clog2(MAX_TRIES + 1);

    localparam logic [2:0] ErrOk      = 3'd0;
    localparam logic [2:0] ErrBadAcc  = 3'd1;
    localparam logic [2:0] ErrPin     = 3'd2;
    localparam logic [2:0] ErrLocked  = 3'd3;
    localparam logic [2:0] ErrFunds   = 3'd4;
    localparam logic [2:0] ErrLimit   = 3'd5;
    localparam logic [2:0] ErrOverflw = 3'd6;
    localparam logic [2:0] ErrBadOp   = 3'd7;

    localparam logic [FAIL_W-1:0] MaxTriesW = FAIL_W'(MAX_TRIES);
    localparam logic [BAL_W:0]    LimitW    = (BAL_W+1)'(WD_LIMIT);

    typedef enum logic [2:0] {
        StAuth = 3'd1,
        StExec = 3'd2,
        StResp = 3'd3,
        StIdle = 3'd7
    } state_e;

    state_e state_q, state_d;

    logic [2:0]       op_q;
    logic [ACC_W-1:0] acc_q;
    logic [PIN_W-1:0] pin_q;
    logic [PIN_W-1:0] new_pin_q;
    logic [BAL_W-1:0] amount_q;

    logic [PIN_W-1:0]  db_pin_q  [NUM_ACCOUNTS];
    logic [BAL_W-1:0]  db_bal_q  [NUM_ACCOUNTS];
    logic [BAL_W-1:0]  db_wd_q   [NUM_ACCOUNTS];
    logic [FAIL_W-1:0] db_fail_q [NUM_ACCOUNTS];
    logic              db_lock_q [NUM_ACCOUNTS];

    logic [2:0]       auth_err_q;
    logic [2:0]       res_err_q;
    logic [BAL_W-1:0] res_bal_q;

    logic             rsp_valid_q;
    logic             success_q;
    logic [2:0]       error_code_q;
    logic [BAL_W-1:0] balance_q;

    logic              accept;
    logic              acc_hit;
    logic [PIN_W-1:0]  cur_pin;
    logic [BAL_W-1:0]  cur_bal;
    logic [BAL_W-1:0]  cur_wd;
    logic [FAIL_W-1:0] cur_fail;
    logic              cur_lock;
    logic [FAIL_W-1:0] fail_next;
    logic [2:0]        auth_err_d;

    logic [BAL_W-1:0] wd_eff;
    logic [BAL_W:0]   dep_sum;
    logic [BAL_W:0]   wd_sum;
    logic [2:0]       exec_err;
    logic [BAL_W-1:0] exec_bal;
    logic [BAL_W-1:0] exec_wd;
    logic             wr_bal;
    logic             wr_wd;
    logic             wr_pin;

    assign accept = bus.req_valid && (state_q == StIdle);

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (accept) state_d = StAuth;
            StAuth:  state_d = StExec;
            StExec:  state_d = StResp;
            StResp:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Account lookup by number; out-of-range numbers simply find no entry.
    always_comb begin
        acc_hit  = 1'b0;
        cur_pin  = '0;
        cur_bal  = '0;
        cur_wd   = '0;
        cur_fail = '0;
        cur_lock = 1'b0;
        for (int i = 0; i < NUM_ACCOUNTS; i++) begin
            if (acc_q == ACC_W'(i + 1)) begin
                acc_hit  = 1'b1;
                cur_pin  = db_pin_q[i];
                cur_bal  = db_bal_q[i];
                cur_wd   = db_wd_q[i];
                cur_fail = db_fail_q[i];
                cur_lock = db_lock_q[i];
            end
        end
    end

    always_comb begin
        fail_next = cur_fail + FAIL_W'(1);
        if (!acc_hit) begin
            auth_err_d = ErrBadAcc;
        end else if (cur_lock) begin
            auth_err_d = ErrLocked;
        end else if (pin_q != cur_pin) begin
            auth_err_d = ErrPin;
        end else begin
            auth_err_d = ErrOk;
        end
    end

    // A rollover coinciding with EXEC clears first, so the limit sees zero.
    assign wd_eff  = bus.day_rollover ? '0 : cur_wd;
    assign dep_sum = {1'b0, cur_bal} + {1'b0, amount_q};
    assign wd_sum  = {1'b0, wd_eff} + {1'b0, amount_q};

    always_comb begin
        exec_err = ErrOk;
        exec_bal = cur_bal;
        exec_wd  = wd_eff;
        wr_bal   = 1'b0;
        wr_wd    = 1'b0;
        wr_pin   = 1'b0;
        if (auth_err_q != ErrOk) begin
            exec_err = auth_err_q;
            exec_bal = '0;
        end else begin
            case (op_q)
                3'd3: ;
                3'd4: begin
                    if ({1'b0, amount_q} > {1'b0, cur_bal}) begin
                        exec_err = ErrFunds;
                    end else if (wd_sum > LimitW) begin
                        exec_err = ErrLimit;
                    end else begin
                        exec_bal = cur_bal - amount_q;
                        exec_wd  = wd_sum[BAL_W-1:0];
                        wr_bal   = 1'b1;
                        wr_wd    = 1'b1;
                    end
                end
                3'd5: begin
                    if (dep_sum[BAL_W]) begin
                        exec_err = ErrOverflw;
                    end else begin
                        exec_bal = dep_sum[BAL_W-1:0];
                        wr_bal   = 1'b1;
                    end
                end
                3'd6: begin
                    if (new_pin_q == cur_pin) begin
                        exec_err = ErrBadOp;
                    end else begin
                        wr_pin = 1'b1;
                    end
                end
                default: exec_err = ErrBadOp;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= StIdle;
            op_q         <= '0;
            acc_q        <= '0;
            pin_q        <= '0;
            new_pin_q    <= '0;
            amount_q     <= '0;
            auth_err_q   <= ErrOk;
            res_err_q    <= ErrOk;
            res_bal_q    <= '0;
            rsp_valid_q  <= 1'b0;
            success_q    <= 1'b0;
            error_code_q <= ErrOk;
            balance_q    <= '0;
            for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                db_pin_q[i]  <= PIN_W'(DEFAULT_PIN);
                db_bal_q[i]  <= BAL_W'(INIT_BAL);
                db_wd_q[i]   <= '0;
                db_fail_q[i] <= '0;
                db_lock_q[i] <= 1'b0;
            end
        end else begin
            state_q <= state_d;

            if (accept) begin
                op_q      <= bus.operation;
                acc_q     <= bus.acc_num;
                pin_q     <= bus.pin;
                new_pin_q <= bus.new_pin;
                amount_q  <= bus.amount;
            end

            if (state_q == StAuth) begin
                auth_err_q <= auth_err_d;
                for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                    if (acc_q == ACC_W'(i + 1) && !cur_lock) begin
                        if (auth_err_d == ErrPin) begin
                            db_fail_q[i] <= fail_next;
                            if (fail_next >= MaxTriesW) db_lock_q[i] <= 1'b1;
                        end else begin
                            db_fail_q[i] <= '0;
                        end
                    end
                end
            end

            if (bus.day_rollover) begin
                for (int i = 0; i < NUM_ACCOUNTS; i++) db_wd_q[i] <= '0;
            end

            // Placed after the rollover clear so the accumulated total wins.
            if (state_q == StExec) begin
                res_err_q <= exec_err;
                res_bal_q <= exec_bal;
                for (int i = 0; i < NUM_ACCOUNTS; i++) begin
                    if (acc_q == ACC_W'(i + 1)) begin
                        if (wr_bal) db_bal_q[i] <= exec_bal;
                        if (wr_wd)  db_wd_q[i]  <= exec_wd;
                        if (wr_pin) db_pin_q[i] <= new_pin_q;
                    end
                end
            end

            rsp_valid_q <= (state_q == StResp);
            if (state_q == StResp) begin
                success_q    <= (res_err_q == ErrOk);
                error_code_q <= res_err_q;
                balance_q    <= res_bal_q;
            end
        end
    end

    assign bus.req_ready  = (state_q == StIdle);
    assign bus.rsp_valid  = rsp_valid_q;
    assign bus.success    = success_q;
    assign bus.error_code = error_code_q;
    assign bus.balance    = balance_q;
    assign bus.state      = state_q;
endmodule

// File: tb/tb_atm_bank_core.sv
// Directed bench for atm_bank_core: hand-computed responses, latency, state walk,
// lockout, daily limit, rollover, overflow and reset abort.
module tb_atm_bank_core;
    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;

    atm_bank_core_if #(.ACC_W(4), .PIN_W(16), .BAL_W(32)) bus ();

    atm_bank_core dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic idle_inputs();
        bus.req_valid    = 1'b0;
        bus.operation    = 3'd0;
        bus.acc_num      = 4'd0;
        bus.pin          = 16'd0;
        bus.new_pin      = 16'd0;
        bus.amount       = 32'd0;
        bus.day_rollover = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_inputs();
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    // One full transaction; inputs are scrambled right after acceptance.
    task automatic run_req(input string tag, input logic [2:0] op, input logic [3:0] acc,
                           input logic [15:0] p, input logic [15:0] np, input logic [31:0] amt,
                           input bit roll, input logic [2:0] exp_err, input logic [31:0] exp_bal);
        int lat;
        lat = 0;
        @(negedge clk);
        check_eq({tag, " ready"}, 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.operation = op;
        bus.acc_num   = acc;
        bus.pin       = p;
        bus.new_pin   = np;
        bus.amount    = amt;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.operation = 3'd5;
        bus.acc_num   = 4'd2;
        bus.pin       = 16'd0;
        bus.new_pin   = 16'd0;
        bus.amount    = 32'd1000;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            bus.day_rollover = roll && (k == 2);
            if (k <= 4) check_eq({tag, " state"}, 64'(bus.state), (k == 4) ? 64'd7 : 64'(k));
            if (bus.rsp_valid) begin
                lat = k;
                break;
            end
        end
        bus.day_rollover = 1'b0;
        check_eq({tag, " latency"}, 64'(lat), 64'd4);
        check_eq({tag, " error_code"}, 64'(bus.error_code), 64'(exp_err));
        check_eq({tag, " success"}, 64'(bus.success), (exp_err == 3'd0) ? 64'd1 : 64'd0);
        check_eq({tag, " balance"}, 64'(bus.balance), 64'(exp_bal));
        @(negedge clk);
        check_eq({tag, " rsp pulse"}, 64'(bus.rsp_valid), 64'd0);
        check_eq({tag, " hold"}, 64'(bus.balance), 64'(exp_bal));
    endtask

    initial begin
        int rsp_seen;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        idle_inputs();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check_eq("rst state", 64'(bus.state), 64'd7);
        check_eq("rst req_ready", 64'(bus.req_ready), 64'd1);
        check_eq("rst rsp_valid", 64'(bus.rsp_valid), 64'd0);
        check_eq("rst success", 64'(bus.success), 64'd0);
        check_eq("rst error_code", 64'(bus.error_code), 64'd0);
        check_eq("rst balance", 64'(bus.balance), 64'd0);

        run_req("a1 bal", 3'd3, 4'd1, 16'd1234, 16'd0, 32'd0, 1'b0, 3'd0, 32'd5000);
        run_req("a1 wd0", 3'd4, 4'd1, 16'd1234, 16'd0, 32'd0, 1'b0, 3'd0, 32'd5000);
        run_req("a1 dep0", 3'd5, 4'd1, 16'd1234, 16'd0, 32'd0, 1'b0, 3'd0, 32'd5000);

        run_req("a2 dep", 3'd5, 4'd2, 16'd1234, 16'd0, 32'd1000, 1'b0, 3'd0, 32'd6000);
        run_req("a2 wd", 3'd4, 4'd2, 16'd1234, 16'd0, 32'd500, 1'b0, 3'd0, 32'd5500);
        run_req("a2 nsf", 3'd4, 4'd2, 16'd1234, 16'd0, 32'd6000, 1'b0, 3'd4, 32'd5500);

        run_req("a3 dep", 3'd5, 4'd3, 16'd1234, 16'd0, 32'd30000, 1'b0, 3'd0, 32'd35000);
        run_req("a3 wd1", 3'd4, 4'd3, 16'd1234, 16'd0, 32'd15000, 1'b0, 3'd0, 32'd20000);
        run_req("a3 lim", 3'd4, 4'd3, 16'd1234, 16'd0, 32'd6000, 1'b0, 3'd5, 32'd20000);
        @(negedge clk);
        bus.day_rollover = 1'b1;
        @(negedge clk);
        bus.day_rollover = 1'b0;
        run_req("a3 retry", 3'd4, 4'd3, 16'd1234, 16'd0, 32'd6000, 1'b0, 3'd0, 32'd14000);
        run_req("a3 dep2", 3'd5, 4'd3, 16'd1234, 16'd0, 32'd20000, 1'b0, 3'd0, 32'd34000);
        run_req("a3 rollwd", 3'd4, 4'd3, 16'd1234, 16'd0, 32'd15000, 1'b1, 3'd0, 32'd19000);
        run_req("a3 lim2", 3'd4, 4'd3, 16'd1234, 16'd0, 32'd6000, 1'b0, 3'd5, 32'd19000);

        run_req("a5 same", 3'd6, 4'd5, 16'd1234, 16'd1234, 32'd0, 1'b0, 3'd7, 32'd5000);
        run_req("a5 chg", 3'd6, 4'd5, 16'd1234, 16'd9012, 32'd0, 1'b0, 3'd0, 32'd5000);
        run_req("a5 old", 3'd3, 4'd5, 16'd1234, 16'd0, 32'd0, 1'b0, 3'd2, 32'd0);
        run_req("a5 new", 3'd3, 4'd5, 16'd9012, 16'd0, 32'd0, 1'b0, 3'd0, 32'd5000);
        run_req("a5 ovf", 3'd5, 4'd5, 16'd9012, 16'd0, 32'hFFFF_EC78, 1'b0, 3'd6, 32'd5000);

        run_req("acc0", 3'd3, 4'd0, 16'd1234, 16'd0, 32'd0, 1'b0, 3'd1, 32'd0);
        run_req("acc11", 3'd3, 4'd11, 16'd1234, 16'd0, 32'd0, 1'b0, 3'd1, 32'd0);
        run_req("op7", 3'd7, 4'd1, 16'd1234, 16'd0, 32'd0, 1'b0, 3'd7, 32'd5000);

        // Reset during EXEC of a deposit: no response, state back to IDLE.
        @(negedge clk);
        bus.req_valid = 1'b1;
        bus.operation = 3'd5;
        bus.acc_num   = 4'd6;
        bus.pin       = 16'd1234;
        bus.amount    = 32'd1000;
        @(posedge clk);
        #1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        check_eq("abort in exec", 64'(bus.state), 64'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort state", 64'(bus.state), 64'd7);
        rsp_seen = 0;
        for (int k = 0; k < 5; k++) begin
            if (bus.rsp_valid) rsp_seen++;
            @(negedge clk);
        end
        check_eq("abort no rsp", 64'(rsp_seen), 64'd0);
        check_eq("abort balance out", 64'(bus.balance), 64'd0);
        run_req("a6 after abort", 3'd3, 4'd6, 16'd1234, 16'd0, 32'd0, 1'b0, 3'd0, 32'd5000);

        run_req("a4 bad1", 3'd3, 4'd4, 16'd1111, 16'd0, 32'd0, 1'b0, 3'd2, 32'd0);
        run_req("a4 bad2", 3'd3, 4'd4, 16'd1111, 16'd0, 32'd0, 1'b0, 3'd2, 32'd0);
        run_req("a4 bad3", 3'd3, 4'd4, 16'd1111, 16'd0, 32'd0, 1'b0, 3'd2, 32'd0);
        run_req("a4 locked", 3'd3, 4'd4, 16'd1234, 16'd0, 32'd0, 1'b0, 3'd3, 32'd0);
        run_req("a4 lockdep", 3'd5, 4'd4, 16'd1234, 16'd0, 32'd10, 1'b0, 3'd3, 32'd0);
        do_reset();
        run_req("a4 unlocked", 3'd3, 4'd4, 16'd1234, 16'd0, 32'd0, 1'b0, 3'd0, 32'd5000);
        run_req("a3 reloaded", 3'd3, 4'd3, 16'd1234, 16'd0, 32'd0, 1'b0, 3'd0, 32'd5000);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
